// File: rtl/complex_counter_pkg.sv
// Shared constants for the binary/Gray up/down counter.
package complex_counter_pkg;

    // Mode encodings: bit 1 selects direction, bit 0 selects Gray output coding.
    localparam logic [1:0] MODE_BIN_UP  = 2'b00;
    localparam logic [1:0] MODE_GRAY_UP = 2'b01;
    localparam logic [1:0] MODE_BIN_DN  = 2'b10;
    localparam logic [1:0] MODE_GRAY_DN = 2'b11;

endpackage

// File: rtl/gray_encoder.sv
// Combinational binary-to-reflected-Gray converter.
module gray_encoder #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/param_complex_counter.sv
// Up/down counter over a binary index with optional Gray-coded output,
// synchronous load, wrap pulse and terminal-count flag.
module param_complex_counter
    import complex_counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [1:0]       Mode,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadValue,
    output logic [WIDTH-1:0] Count,
    output logic             Wrap,
    output logic             TC
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] idx_q;
    logic [WIDTH-1:0] idx_d;
    logic [WIDTH-1:0] gray_d;
    logic [WIDTH-1:0] count_d;
    logic             wrap_d;
    logic             dir_down;
    logic             gray_sel;

    assign dir_down = (Mode == MODE_BIN_DN) || (Mode == MODE_GRAY_DN);
    assign gray_sel = (Mode == MODE_GRAY_UP) || (Mode == MODE_GRAY_DN);

    // Terminal count looks only at the index and direction, never at Enable.
    assign TC = dir_down ? (idx_q == '0) : (idx_q == ALL_ONES);

    // Next index: load beats advance, advance beats hold.
    always_comb begin
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (Load) begin
            idx_d = LoadValue;
        end else if (Enable) begin
            idx_d  = dir_down ? (idx_q - ONE) : (idx_q + ONE);
            wrap_d = TC;
        end
    end

    // Output coding is chosen from the index being stored this edge, so a
    // mode change re-encodes Count without touching the sequence position.
    gray_encoder #(
        .WIDTH (WIDTH)
    ) u_gray (
        .bin  (idx_d),
        .gray (gray_d)
    );

    assign count_d = gray_sel ? gray_d : idx_d;

    // Index, registered count and wrap pulse; reset clears all asynchronously.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            idx_q <= '0;
            Count <= '0;
            Wrap  <= 1'b0;
        end else begin
            idx_q <= idx_d;
            Count <= count_d;
            Wrap  <= wrap_d;
        end
    end

endmodule

// File: doc/param_complex_counter.md
PARAM_COMPLEX_COUNTER -- requirements
Module: param_complex_counter

Interface
REQ-001 Parameters SHALL be exactly one per line, as follows.
REQ-002 WIDTH, 4, counter width in bits; legal range 2..16.
REQ-003 Ports SHALL be exactly the following, in this order.
REQ-004 Clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Reset  input  1  asynchronous, active-high reset.
REQ-006 Enable  input  1  count advance on the next rising edge when high.
REQ-007 Mode  input  2  00 binary up, 01 Gray up, 10 binary down, 11 Gray down.
REQ-008 Load  input  1  synchronous load of LoadValue on the next rising edge when high.
REQ-009 LoadValue  input  WIDTH  binary index to load.
REQ-010 Count  output  WIDTH  registered count, binary or Gray coded per Mode[0].
REQ-011 Wrap  output  1  registered one-cycle pulse flagging a wrap-around on an advance.
REQ-012 TC  output  1  combinational terminal-count flag: the next advance in the current direction wraps.

Function
REQ-013 The block SHALL hold an internal WIDTH-bit binary index; Count SHALL be a registered encoding of it.
REQ-014 The next index SHALL follow priority Load > Enable > hold.
- Load: LoadValue.
- Enable: index+1 if Mode[1]=0, index-1 if Mode[1]=1, modulo 2^WIDTH.
- Otherwise: index unchanged.
REQ-015 On each rising edge, Count SHALL load Gray(next index) = next^(next>>1) if Mode[0]=1, else next index unchanged.
REQ-016 Latency from a sampled Enable or Load to the updated Count SHALL be exactly one clock.
REQ-017 A Mode change SHALL take effect at the next edge without disturbing the index: sequence position continues; only encoding and direction change.
REQ-018 With Enable=0 and Load=0, a Mode[0] change SHALL re-encode Count on the next edge; the index SHALL stay the same.
REQ-019 Wrap SHALL be 1 for exactly the cycle after an advance that goes from the all-ones index to 0 (up) or from 0 to the all-ones index (down); otherwise 0.
REQ-020 A Load SHALL never assert Wrap, even when Enable is also high.
REQ-021 TC SHALL be 1 when the index is all-ones and Mode[1]=0, or the index is 0 and Mode[1]=1; it SHALL NOT depend on Enable.
REQ-022 No X SHALL propagate to outputs when inputs are known.

Reset
REQ-023 Reset high SHALL immediately (asynchronously) force index=0, Count=0, Wrap=0, regardless of the clock.
REQ-024 While Reset is high, Load and Enable SHALL be ignored.
REQ-025 After Reset deasserts, the first rising edge SHALL apply normal next-state rules; asserting Reset mid-sequence SHALL abandon the sequence with no residual Wrap.
REQ-026 During reset, TC SHALL read 1 if Mode[1]=1, else 0 (index 0).

Structure
REQ-027 A package complex_counter_pkg SHALL hold the Mode encodings as named 2-bit constants: MODE_BIN_UP, MODE_GRAY_UP, MODE_BIN_DN, MODE_GRAY_DN.
REQ-028 The binary-to-Gray conversion SHALL be a parametrised combinational sub-module gray_encoder (WIDTH in, WIDTH out), instantiated once.
REQ-029 The total register count SHALL be WIDTH (index) + WIDTH (Count) + 1 (Wrap).

Verification (WIDTH=3, 10 ns clock)
REQ-030 Reset high 12 ns then low, Mode=00, Enable=1 -> Count 000,001,...,111,000; Wrap high only the cycle after 111->000; TC high while Count=111.
REQ-031 Mode=01, Enable=1 from index 0 -> Count 000,001,011,010,110,111,101,100,000; exactly one bit changes per step.
REQ-032 Mode=10, Enable=1 after reset -> Count 111,110,...,000,111; Wrap pulses after 000->111.
REQ-033 At index 5 (binary Count=101), switch Mode 00->01 with Enable=0 -> Count becomes 111 (Gray of 5) next edge; then Enable=1 -> 101 (Gray of 6).
REQ-034 Load=1, LoadValue=111, Enable=1, Mode=00 -> Count=111, Wrap=0; next Enable edge -> Count=000, Wrap=1.
REQ-035 Reset pulsed asynchronously between edges at Count=110 -> Count=000 and Wrap=0 before the next edge; counting resumes from 000 after deassertion.
